// File: rtl/cache_def.sv
// rtl/cache_def.sv - shared d_cache / main memory types and constants
//
// Contents:
//   MEM_LATENCY   default request-to-ready latency in cycles
//   MEM_LINES     default number of 128-bit memory lines
//   mem_req_type  d_cache -> memory request {addr, data, rw, valid}
//   mem_data_type memory -> d_cache response {data, ready}
//   mem_state_e   responder FSM states
package cache_def;

  localparam int MEM_LATENCY = 4;
  localparam int MEM_LINES   = 1024;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;     // 1 = write
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - MEM_LINES x 128-bit line storage
//
// Ports:
//   clk    clock, writes on rising edge
//   we     write enable
//   idx    line index
//   wdata  line written when we=1
//   rdata  combinational read of line idx
// The array has no reset; contents are undefined until written.
module mem_line_array #(
  parameter int MEM_LINES = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_LINES)-1:0] idx,
  input  logic [127:0]                 wdata,
  output logic [127:0]                 rdata
);

  logic [127:0] lines [MEM_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      lines[idx] <= wdata;
    end
  end

  assign rdata = lines[idx];

endmodule

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - memory-side responder for d_cache refill/write-back
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   mem_req_i   request from d_cache {addr, data, rw, valid}
//   mem_data_o  response to d_cache {data, ready}
//   no_rd_o     completed read count (wraps)
//   no_wr_o     completed write count (wraps)
// One request at a time: accepted in IDLE, ready pulses for one cycle
// exactly LATENCY cycles later, then the FSM returns to IDLE.
module main_mem_ctrl
  import cache_def::*;
#(
  parameter int LATENCY   = cache_def::MEM_LATENCY,
  parameter int MEM_LINES = cache_def::MEM_LINES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_req_type  mem_req_i,
  output mem_data_type mem_data_o,
  output logic [31:0]  no_rd_o,
  output logic [31:0]  no_wr_o
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [127:0]      data_q;
  logic              rw_q;
  logic              line_we;
  logic [127:0]      line_rdata;
  logic              accept;

  // Only the line-index bits of the address matter; the byte offset and
  // the bits above the array size are dropped so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_i.addr[31:4+IDX_W], mem_req_i.addr[3:0]};

  assign accept = (state_q == IDLE) && mem_req_i.valid;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_req_i.valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q <= 8'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request, latency counter and statistics. The request is only
  // captured in IDLE, so mem_req_i is ignored for the rest of the transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      no_rd_o <= '0;
      no_wr_o <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= LAT_M1;
        idx_q  <= mem_req_i.addr[4 +: IDX_W];
        data_q <= mem_req_i.data;
        rw_q   <= mem_req_i.rw;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (state_q == RESP) begin
        if (rw_q) begin
          no_wr_o <= no_wr_o + 32'd1;
        end else begin
          no_rd_o <= no_rd_o + 32'd1;
        end
      end
    end
  end

  // Outputs: data is non-zero only for a read in RESP; a write commits on
  // the edge that ends RESP. Reset forces IDLE, which also blocks the commit.
  always_comb begin
    mem_data_o = '0;
    line_we    = 1'b0;
    if (state_q == RESP) begin
      mem_data_o.ready = 1'b1;
      if (rw_q) begin
        line_we = rst_ni;
      end else begin
        mem_data_o.data = line_rdata;
      end
    end
  end

  mem_line_array #(
    .MEM_LINES(MEM_LINES)
  ) u_lines (
    .clk   (clk_i),
    .we    (line_we),
    .idx   (idx_q),
    .wdata (data_q),
    .rdata (line_rdata)
  );

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - directed self-checking bench for main_mem_ctrl
module tb_main_mem_ctrl;
  import cache_def::*;

  logic clk;
  logic rst_n;

  // Instance 0: LATENCY 4, 1: LATENCY 1, 2: LATENCY 2, 3: LATENCY 7
  mem_req_type  req [4];
  mem_data_type rsp [4];
  logic [31:0]  nrd [4];
  logic [31:0]  nwr [4];

  int vectors;
  int miscompares;

  main_mem_ctrl #(.LATENCY(4), .MEM_LINES(1024)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[0]), .mem_data_o(rsp[0]),
    .no_rd_o(nrd[0]), .no_wr_o(nwr[0]));
  main_mem_ctrl #(.LATENCY(1), .MEM_LINES(1024)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[1]), .mem_data_o(rsp[1]),
    .no_rd_o(nrd[1]), .no_wr_o(nwr[1]));
  main_mem_ctrl #(.LATENCY(2), .MEM_LINES(1024)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[2]), .mem_data_o(rsp[2]),
    .no_rd_o(nrd[2]), .no_wr_o(nwr[2]));
  main_mem_ctrl #(.LATENCY(7), .MEM_LINES(1024)) u_l7 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[3]), .mem_data_o(rsp[3]),
    .no_rd_o(nrd[3]), .no_wr_o(nwr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance i. lat is the number of cycles from the
  // acceptance edge to the cycle where ready is seen (-1 if never).
  task automatic xact(input int i, input logic rw, input logic [31:0] a,
                      input logic [127:0] d, output int lat,
                      output logic [127:0] rdata, output logic ready_after);
    @(negedge clk);
    req[i] = '{addr: a, data: d, rw: rw, valid: 1'b1};
    @(negedge clk);
    req[i].valid = 1'b0;
    lat = -1;
    rdata = '0;
    for (int n = 1; n <= 300; n++) begin
      if (rsp[i].ready) begin
        lat = n;
        rdata = rsp[i].data;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    ready_after = rsp[i].ready;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [127:0] rd;
    logic rdy_after;
    logic [127:0] d1, da, db, dw, h1, h2, fd, sd;
    int sweep_lat [3];
    int first, second;
    logic seen_ready;

    vectors = 0;
    miscompares = 0;
    d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    da = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
    db = 128'hBBBB_9999_8888_7777_6666_5555_4444_BBBB;
    dw = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    h1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    h2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    sweep_lat = '{1, 2, 7};
    for (int i = 0; i < 4; i++) req[i] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(rsp[0].ready), 128'(0));
    check("rst_data", rsp[0].data, '0);
    check("rst_no_rd", 128'(nrd[0]), 128'(0));
    check("rst_no_wr", 128'(nwr[0]), 128'(0));
    rst_n = 1'b1;

    // Write then read the same line
    xact(0, 1'b1, 32'h0000_0040, d1, lat, rd, rdy_after);
    check("wr_lat", 128'(lat), 128'(4));
    check("wr_resp_data", rd, '0);
    check("wr_one_cycle", 128'(rdy_after), 128'(0));
    xact(0, 1'b0, 32'h0000_0040, '0, lat, rd, rdy_after);
    check("rd_lat", 128'(lat), 128'(4));
    check("rd_data", rd, d1);
    check("rd_one_cycle", 128'(rdy_after), 128'(0));
    check("no_wr_1", 128'(nwr[0]), 128'(1));
    check("no_rd_1", 128'(nrd[0]), 128'(1));
    @(negedge clk);
    check("idle_data_zero", rsp[0].data, '0);

    // Latency sweep on the LATENCY 1, 2 and 7 instances
    for (int k = 0; k < 3; k++) begin
      xact(k + 1, 1'b1, 32'h0000_0300, dw ^ 128'(k), lat, rd, rdy_after);
      check($sformatf("sweep%0d_wr_lat", sweep_lat[k]), 128'(lat), 128'(sweep_lat[k]));
      check($sformatf("sweep%0d_wr_pulse", sweep_lat[k]), 128'(rdy_after), 128'(0));
      xact(k + 1, 1'b0, 32'h0000_0300, '0, lat, rd, rdy_after);
      check($sformatf("sweep%0d_rd_lat", sweep_lat[k]), 128'(lat), 128'(sweep_lat[k]));
      check($sformatf("sweep%0d_rd_data", sweep_lat[k]), rd, dw ^ 128'(k));
      check($sformatf("sweep%0d_rd_pulse", sweep_lat[k]), 128'(rdy_after), 128'(0));
    end

    // Address wrap and ignored byte offset
    xact(0, 1'b1, 32'h0000_4000, dw, lat, rd, rdy_after);
    xact(0, 1'b0, 32'h0000_0000, '0, lat, rd, rdy_after);
    check("wrap_rd_0", rd, dw);
    xact(0, 1'b0, 32'h0000_000F, '0, lat, rd, rdy_after);
    check("wrap_rd_F", rd, dw);
    check("wrap_d1_intact", 128'(nwr[0]), 128'(2));

    // Request hold: valid stays high, addr changes mid-WAIT
    xact(0, 1'b1, 32'h0000_0100, h1, lat, rd, rdy_after);
    xact(0, 1'b1, 32'h0000_0200, h2, lat, rd, rdy_after);
    @(negedge clk);
    req[0] = '{addr: 32'h0000_0100, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    first = -1;
    second = -1;
    fd = '0;
    sd = '0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 2) req[0].addr = 32'h0000_0200;
      if (n == 6) req[0].valid = 1'b0;
      if (rsp[0].ready) begin
        if (first < 0) begin
          first = n;
          fd = rsp[0].data;
        end else if (second < 0) begin
          second = n;
          sd = rsp[0].data;
        end
      end
      @(negedge clk);
    end
    check("hold_first_lat", 128'(first), 128'(4));
    check("hold_first_data", fd, h1);
    check("hold_second_lat", 128'(second), 128'(9));
    check("hold_second_data", sd, h2);

    // Read counter wrap
    @(negedge clk);
    force u_l4.no_rd_o = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_l4.no_rd_o;
    check("pre_wrap_no_rd", 128'(nrd[0]), 128'(32'hFFFF_FFFF));
    xact(0, 1'b0, 32'h0000_0040, '0, lat, rd, rdy_after);
    check("no_rd_wrap", 128'(nrd[0]), 128'(0));

    // Reset in WAIT of a write aborts it
    xact(0, 1'b1, 32'h0000_0080, da, lat, rd, rdy_after);
    @(negedge clk);
    req[0] = '{addr: 32'h0000_0080, data: db, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    req[0].valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready_async", 128'(rsp[0].ready), 128'(0));
    check("abort_no_wr_async", 128'(nwr[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp[0].ready) seen_ready = 1'b1;
    end
    check("abort_no_ready", 128'(seen_ready), 128'(0));
    check("abort_no_wr", 128'(nwr[0]), 128'(0));
    xact(0, 1'b0, 32'h0000_0080, '0, lat, rd, rdy_after);
    check("abort_rd_lat", 128'(lat), 128'(4));
    check("abort_rd_old", rd, da);
    check("abort_no_rd", 128'(nrd[0]), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 The module SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to the ready pulse; legal values are 1 to 255.
REQ-002 The module SHALL have parameter MEM_LINES, default 1024, meaning the number of 128-bit lines stored; it is a power of two.
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-005 Port mem_req_i, input, mem_req_type, SHALL carry the request from d_cache: addr[31:0], data[127:0], rw (1 = write), valid.
REQ-006 Port mem_data_o, output, mem_data_type, SHALL carry the response to d_cache: data[127:0], ready.
REQ-007 Port no_rd_o, output, 32 bits, SHALL count completed reads.
REQ-008 Port no_wr_o, output, 32 bits, SHALL count completed writes.

Function
REQ-009 The block SHALL be the memory-side responder of the d_cache refill/write-back protocol, one request at a time.
REQ-010 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-011 In IDLE with mem_req_i.valid=1, the block SHALL latch addr, rw and data, load the latency counter with LATENCY-1, and enter RESP if LATENCY=1, else WAIT.
REQ-012 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL enter RESP when the counter reaches 1.
REQ-013 The latched request SHALL ignore all mem_req_i changes during WAIT and RESP.
REQ-014 A request accepted on edge T SHALL produce ready=1 in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
REQ-015 ready SHALL be high for exactly one cycle, in RESP only.
REQ-016 RESP SHALL always return to IDLE.
REQ-017 IDLE SHALL sample valid on the edge following the RESP cycle; back-to-back requests are therefore spaced LATENCY+1 cycles apart.
REQ-018 Line index SHALL be addr[4+log2(MEM_LINES)-1:4].
REQ-019 addr[3:0] SHALL be ignored.
REQ-020 Higher address bits SHALL be ignored, so addresses wrap modulo MEM_LINES lines.
REQ-021 A read SHALL drive mem_data_o.data with the indexed line during the RESP cycle.
REQ-022 mem_data_o.data SHALL be 0 whenever ready=0.
REQ-023 A write SHALL commit the latched 128-bit data into the indexed line on the edge ending the RESP cycle.
REQ-024 During the RESP cycle of a write, mem_data_o.data SHALL be 0.
REQ-025 A read following a write to the same line SHALL return the written data.
REQ-026 no_rd_o or no_wr_o SHALL increment by 1 on the edge ending each RESP cycle, according to rw.
REQ-027 Both counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-028 While rst_ni=0, the FSM SHALL be IDLE, the counter 0, mem_data_o.ready 0, mem_data_o.data 0, no_rd_o 0 and no_wr_o 0, asynchronously.
REQ-029 Reset in WAIT or RESP SHALL abort the request: no write commit, no counter increment, no ready.
REQ-030 Reset SHALL NOT modify line-array contents; contents are undefined at power-up.
REQ-031 The first request SHALL be accepted on the first rising edge with rst_ni=1 and valid=1.

Structure
REQ-032 mem_req_type, mem_data_type, MEM_LATENCY and MEM_LINES SHALL reside in package cache_def, shared with d_cache.
REQ-033 The storage SHALL be sub-module mem_line_array: MEM_LINES x 128 bits, synchronous write, combinational read, no reset.
REQ-034 FSM, latency counter and statistics SHALL reside in main_mem_ctrl.

Verification
REQ-035 Write then read: write addr 0x0000_0040, data 0x0123..CDEF; ready at +4 cycles; read 0x0000_0040 returns the same data at +4; no_wr_o=1, no_rd_o=1.
REQ-036 Latency sweep: for LATENCY 1, 2 and 7, ready rises exactly LATENCY cycles after valid is sampled, for exactly one cycle.
REQ-037 Request hold: valid held high with addr changed mid-WAIT; the response uses the first addr, and the next acceptance is exactly LATENCY+1 cycles after the first.
REQ-038 Wrap: write line at addr 0x0000_4000 (MEM_LINES=1024); read addr 0x0000_0000 returns the same data; addr 0x0000_000F is equivalent to 0x0.
REQ-039 Reset mid-write: rst_ni low in WAIT of a write to 0x80 previously holding A; no ready; no_wr_o=0; a later read of 0x80 returns A.
REQ-040 Counter wrap: preload no_rd_o=0xFFFFFFFF via force; one read returns no_rd_o=0.
